// File: rtl/imem_loader.sv
// imem_loader
//   Write-side companion to the CPU's 256x16 instruction memory. Accepts a
//   byte stream over a valid/ready handshake. It packs pairs of bytes (high
//   byte first) into words and writes them to consecutive addresses starting
//   at 0. It then checks the load against a trailing checksum word. The CPU
//   is held in reset until a load has completed and verified successfully.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   one-cycle pulse that begins a load (ignored while busy)
//   word_count in   number of words to load, sampled on an accepted start
//   rx_data    in   incoming byte
//   rx_valid   in   rx_data is valid
//   rx_ready   out  loader accepts a byte this cycle
//   we         out  instruction-memory write enable (registered pulse)
//   waddr      out  write address (registered)
//   wdata      out  write data (registered)
//   busy       out  a load is in progress
//   done       out  last load completed with a matching checksum (sticky)
//   err        out  last load failed (sticky)
//   cpu_hold   out  holds the CPU pipeline in reset

module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [8:0]        word_count,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  typedef enum logic [2:0] {
    IDLE, HI, LO, WR, CHI, CLO, DONE, ERR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [8:0]          wordsLeft_q, wordsLeft_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic [7:0]          hi_q, hi_d;
  logic [7:0]          chkHi_q, chkHi_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                xfer;
  logic [DATA_W-1:0]   chkTotal;
  logic                countBad;

  // Status outputs are pure functions of the registered state, so rx_ready
  // never depends combinationally on rx_valid.
  assign rx_ready = (state_q == HI) || (state_q == LO) ||
                    (state_q == CHI) || (state_q == CLO);
  assign busy     = rx_ready || (state_q == WR);
  assign done     = (state_q == DONE);
  assign err      = (state_q == ERR);
  assign cpu_hold = (state_q != DONE);
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;

  assign xfer     = rx_valid && rx_ready;
  // Held in a 16-bit net so the carry out of the checksum addition is dropped.
  assign chkTotal = sum_q + {chkHi_q, rx_data};
  assign countBad = (word_count == 9'd0) || (int'(word_count) > MAX_WORDS);

  // Next-state logic. The write port is loaded on the low-byte transfer, so
  // we/waddr/wdata come straight from flops during the single WR cycle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    wordsLeft_d = wordsLeft_q;
    sum_d       = sum_q;
    hi_d        = hi_q;
    chkHi_d     = chkHi_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          if (countBad) begin
            state_d = ERR;
          end else begin
            wordsLeft_d = word_count;
            ptr_d       = '0;
            sum_d       = '0;
            state_d     = HI;
          end
        end
      end
      HI: begin
        if (xfer) begin
          hi_d    = rx_data;
          state_d = LO;
        end
      end
      LO: begin
        if (xfer) begin
          we_d    = 1'b1;
          waddr_d = ptr_q;
          wdata_d = {hi_q, rx_data};
          state_d = WR;
        end
      end
      WR: begin
        sum_d       = sum_q + wdata_q;
        ptr_d       = ptr_q + 1'b1;
        wordsLeft_d = wordsLeft_q - 1'b1;
        // Leaving for CHI before ptr wraps means address 0 is never rewritten.
        state_d     = (wordsLeft_q == 9'd1) ? CHI : HI;
      end
      CHI: begin
        if (xfer) begin
          chkHi_d = rx_data;
          state_d = CLO;
        end
      end
      CLO: begin
        if (xfer) begin
          state_d = (chkTotal == '0) ? DONE : ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      wordsLeft_q <= '0;
      sum_q       <= '0;
      hi_q        <= '0;
      chkHi_q     <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wordsLeft_q <= wordsLeft_d;
      sum_q       <= sum_d;
      hi_q        <= hi_d;
      chkHi_q     <= chkHi_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [8:0]  word_count;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        we;
  logic [7:0]  waddr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;

  int checks = 0;
  int errors = 0;
  int writeCount = 0;

  logic [23:0] expQ[$];
  logic [15:0] words [256];
  logic [15:0] memImg [256];
  logic [15:0] memA [8];

  imem_loader #(.ADDR_W(8), .DATA_W(16), .MAX_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done),
    .err(err), .cpu_hold(cpu_hold)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Write monitor: every write pulse is matched against the oldest expected
  // write, and recorded into a shadow copy of the instruction memory.
  always @(negedge clk) begin
    logic [23:0] exp;
    if (rst_n && we) begin
      checkOutput("rx_ready_in_WR", {31'd0, rx_ready}, 32'd0);
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write actual=%0h:%0h expected=none",
                 waddr, wdata);
      end else begin
        exp = expQ.pop_front();
        checkOutput("waddr", {24'd0, waddr}, {24'd0, exp[23:16]});
        checkOutput("wdata", {16'd0, wdata}, {16'd0, exp[15:0]});
      end
      writeCount++;
      memImg[waddr] = wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte after an optional idle gap and returns one step after
  // the edge that accepted it.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int budget;
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    budget   = 0;
    while (!rx_ready && budget < 1000) begin
      tick();
      budget++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL byte_timeout actual=rx_ready_low expected=rx_ready_high");
    end else begin
      tick();
    end
    rx_valid = 1'b0;
  endtask

  task automatic pulseStart(input int n);
    start      = 1'b1;
    word_count = 9'(n);
    tick();
    start      = 1'b0;
  endtask

  function automatic logic [15:0] calcChk(input int n);
    logic [15:0] s = 16'd0;
    for (int i = 0; i < n; i++) s = s + words[i];
    return 16'd0 - s;
  endfunction

  function automatic int pickGap(input int gapMax);
    return (gapMax == 0) ? 0 : int'($urandom_range(gapMax, 0));
  endfunction

  task automatic sendWord(input int idx, input int gapMax);
    expQ.push_back({8'(idx), words[idx]});
    applyStimulus(words[idx][15:8], pickGap(gapMax));
    applyStimulus(words[idx][7:0], pickGap(gapMax));
  endtask

  task automatic loadWords(input int n, input logic [15:0] chk, input int gapMax);
    pulseStart(n);
    for (int i = 0; i < n; i++) sendWord(i, gapMax);
    applyStimulus(chk[15:8], pickGap(gapMax));
    applyStimulus(chk[7:0], pickGap(gapMax));
  endtask

  task automatic checkStatus(input string tag, input logic b, input logic d,
                             input logic e, input logic h);
    checkOutput({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
    checkOutput({tag, "_done"}, {31'd0, done}, {31'd0, d});
    checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, e});
    checkOutput({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, h});
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    checkOutput({tag, "_we"}, {31'd0, we}, 32'd0);
    checkOutput({tag, "_waddr"}, {24'd0, waddr}, 32'd0);
    checkOutput({tag, "_wdata"}, {16'd0, wdata}, 32'd0);
    checkStatus(tag, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int wc0;
    logic [15:0] streamWords [8];
    streamWords = '{16'h0102, 16'hF00D, 16'h8000, 16'h00FF,
                    16'hDEAD, 16'hBEEF, 16'h7FFF, 16'h1357};
    rst_n      = 1'b0;
    start      = 1'b0;
    word_count = 9'd0;
    rx_data    = 8'd0;
    rx_valid   = 1'b0;
    tick();
    tick();
    checkResetState("reset");
    rst_n = 1'b1;
    tick();

    // Basic load: 12 34 AB CD, checksum 41 FF (0x1234+0xABCD+0x41FF = 0x10000).
    words[0] = 16'h1234;
    words[1] = 16'hABCD;
    loadWords(2, 16'h41FF, 0);
    checkStatus("basic", 1'b0, 1'b1, 1'b0, 1'b0);

    // Bad checksum: same words still written, then err.
    loadWords(2, 16'h41FE, 0);
    checkStatus("badchk", 1'b0, 1'b0, 1'b1, 1'b1);

    // Streaming without gaps, then with random gaps; images must match.
    for (int i = 0; i < 8; i++) words[i] = streamWords[i];
    loadWords(8, calcChk(8), 0);
    checkStatus("stream0", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      memA[i]   = memImg[i];
      memImg[i] = 16'h0000;
    end
    loadWords(8, calcChk(8), 5);
    checkStatus("streamgap", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("stream_image", {16'd0, memImg[i]}, {16'd0, memA[i]});
      checkOutput("stream_content", {16'd0, memImg[i]}, {16'd0, streamWords[i]});
    end

    // word_count = 0 fails on the next cycle with no writes.
    wc0 = writeCount;
    pulseStart(0);
    checkStatus("wc0", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("wc0_no_write", writeCount, wc0);

    // word_count = 257 is beyond the memory.
    pulseStart(257);
    checkStatus("wc257", 1'b0, 1'b0, 1'b1, 1'b1);

    // Full 256-word load covering addresses 0..255.
    for (int i = 0; i < 256; i++) words[i] = 16'((i * 16'h0101) ^ 16'h5A3C);
    wc0 = writeCount;
    loadWords(256, calcChk(256), 0);
    checkStatus("wc256", 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("wc256_writes", writeCount - wc0, 32'd256);

    // Reset after 3 of 6 bytes abandons the load.
    words[0] = 16'h1234;
    words[1] = 16'hABCD;
    pulseStart(2);
    sendWord(0, 0);
    applyStimulus(8'hAB, 0);
    rst_n = 1'b0;
    tick();
    checkResetState("midreset");
    rst_n = 1'b1;
    tick();
    checkResetState("afterreset");

    // A start while busy (with an illegal count) is ignored.
    pulseStart(2);
    sendWord(0, 0);
    pulseStart(0);
    checkStatus("busystart", 1'b1, 1'b0, 1'b0, 1'b1);
    sendWord(1, 1);
    applyStimulus(8'h41, 0);
    applyStimulus(8'hFF, 0);
    checkStatus("busystart_end", 1'b0, 1'b1, 1'b0, 1'b0);

    // A new start from DONE clears done and holds the CPU again.
    pulseStart(1);
    checkStatus("restart", 1'b1, 1'b0, 1'b0, 1'b1);
    sendWord(0, 0);
    applyStimulus(8'hED, 0);
    applyStimulus(8'hCC, 0);
    checkStatus("restart_end", 1'b0, 1'b1, 1'b0, 1'b0);

    tick();
    checkOutput("pending_writes", expQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the CPU's 256x16 instruction memory.
- Receives a byte stream over a valid/ready handshake, for example from a UART receiver or a debug port.
- Assembles the bytes into 16-bit words, high byte first, and writes them to consecutive instruction-memory addresses starting at 0.
- Checks the load against a trailing checksum word.
- Holds the CPU in reset (cpu_hold) until a load has completed and verified successfully.

Parameters:
- ADDR_W, 8: instruction-memory address width.
- DATA_W, 16: instruction word width. Fixed at 2 bytes; other values are unsupported.
- MAX_WORDS, 256: largest legal word_count, equal to 2**ADDR_W.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERR.
- word_count  in  9  number of instruction words to load. Sampled on the accepted start.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- we  out  1  instruction-memory write enable, one-cycle pulse.
- waddr  out  ADDR_W  write address.
- wdata  out  DATA_W  write data.
- busy  out  1  a load is in progress.
- done  out  1  last load completed and checksum matched. Sticky.
- err  out  1  last load failed (bad checksum or illegal word_count). Sticky.
- cpu_hold  out  1  holds the CPU pipeline in reset.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - rx_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0, cpu_hold=1.
  - Internal pointer, words-left counter and 16-bit sum all clear to 0.
- Reset mid-load:
  - Same result; the load is abandoned.
  - Words already written stay in memory, but cpu_hold stays 1.
- Byte transfer: occurs only in a cycle where rx_valid and rx_ready are both 1.
  - rx_ready=1 only in states HI, LO, CHI and CLO.
  - rx_ready does not depend combinationally on rx_valid.
- State machine:
  - IDLE, DONE, ERR: an accepted start does the following.
    - If word_count is 0 or greater than MAX_WORDS, go to ERR with err=1 and done=0.
    - Otherwise latch word_count into words_left, clear ptr and sum, set done=0 and err=0, and go to HI.
  - HI: on transfer, hi <= rx_data, go to LO.
  - LO: on transfer, lo <= rx_data, go to WR.
  - WR (exactly one cycle):
    - we=1, waddr=ptr, wdata={hi,lo}.
    - sum <= sum + {hi,lo}, modulo 2^16.
    - ptr <= ptr+1; words_left <= words_left-1.
    - Go to CHI if words_left was 1, else HI.
  - CHI: on transfer, capture the checksum high byte, go to CLO.
  - CLO: on transfer, compute sum + {chk_hi, rx_data} modulo 2^16.
    - If the result is 0, go to DONE with done=1.
    - Otherwise go to ERR with err=1.
    - No memory write occurs for the checksum word.
- busy=1 in HI, LO, WR, CHI and CLO.
- cpu_hold=0 only in DONE; it is 1 in every other state.
- start asserted while busy is ignored and has no effect.
- Latency:
  - The write pulse occurs in the cycle after the low byte's transfer cycle.
  - Peak throughput is 2 bytes per 3 cycles, because of the WR bubble.
  - done/err assert in the cycle after the checksum low byte is accepted.
- Address range and wrap:
  - ptr is ADDR_W bits. A 256-word load writes addresses 0..255 exactly.
  - Wrap back to 0 never produces a write, because CHI is entered first.
- Registered outputs: we, waddr and wdata are all registered. They are stable for the whole WR cycle and waddr/wdata hold their last values afterwards.
- Gaps in the byte stream: rx_valid low stalls the FSM indefinitely in the current state. There is no timeout.

Test Plan:
- Basic load: start with word_count=2, then bytes 12 34 AB CD 41 FF.
  - Expect we pulses writing waddr=0 wdata=0x1234, then waddr=1 wdata=0xABCD.
  - Expect done=1, err=0, cpu_hold=0, busy=0.
- Bad checksum: same load with a trailing 41 FE.
  - Expect the two writes still to occur, then err=1, done=0, cpu_hold=1.
- Streaming with gaps: rx_valid held high continuously, then repeated with random 0-5 cycle gaps.
  - Expect rx_ready low in every WR cycle.
  - Expect no byte lost or duplicated, and identical memory contents in both runs.
- Boundaries:
  - word_count=0 gives err=1 the next cycle with no writes.
  - word_count=257 gives err=1.
  - word_count=256 with matching checksum writes waddr 0..255 and then done=1.
- Reset and start interaction:
  - rst_n=0 after 3 of 6 bytes: all outputs return to reset values, with cpu_hold=1.
  - A start pulse mid-load is ignored; the original load completes with done=1.
  - A new start from DONE clears done and re-asserts cpu_hold.
